mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the single 16-bit synchronous memory port (4096 words, 12-bit word address) between the CPU instruction-fetch requester (read-only) and the load/store requester (read/write). It sits between the core and the memory controller outputs, and drives the memory enable, read/write strobes, address and write data. It routes 1-cycle-latency read data back to whichever requester issued the read. Load/store has priority, with a streak limit that guarantees fetch forward progress.

Parameters:
ADDR_WIDTH, 12, word address width (memory depth 2**ADDR_WIDTH words)
DATA_WIDTH, 16, memory word width
MAX_LS_STREAK, 4, max consecutive load/store grants while fetch is pending (>=1)
CNT_WIDTH, 16, width of performance counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  ADDR_WIDTH  fetch word address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_WIDTH  fetch read data
ls_req  in  1  load/store request
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_WIDTH  load/store word address
ls_wdata  in  DATA_WIDTH  store data
ls_gnt  out  1  load/store request accepted this cycle (write is complete at this edge)
ls_rvalid  out  1  load data valid
ls_rdata  out  DATA_WIDTH  load data
to_mem_mem_enable  out  1  memory enable
to_mem_read_enable  out  1  memory read strobe
to_mem_write_enable  out  1  memory write strobe
to_mem_address  out  ADDR_WIDTH  memory address
to_mem_data  out  DATA_WIDTH  memory write data
from_mem_data  in  DATA_WIDTH  memory read data, valid the cycle after a read
perf_if_grants  out  CNT_WIDTH  fetch grant count
perf_ls_grants  out  CNT_WIDTH  load/store grant count
perf_conflicts  out  CNT_WIDTH  cycles where both requesters asked and one waited

Behaviour:
- Grant decision is combinational in the same cycle. The request is accepted at the rising edge where gnt=1, and the requester must hold req/addr/we/wdata stable until granted.
- ls wins if ls_req && (!if_req || streak < MAX_LS_STREAK). Otherwise if_req wins. Grants are one-hot; at most one access per cycle.
- streak register (clog2(MAX_LS_STREAK+1) bits):
  - +1 on an ls grant while if_req=1, saturating at MAX_LS_STREAK;
  - cleared on an if grant, or on any cycle with if_req=0.
- Memory side, no grant: all strobes 0, address 0, data 0.
- Memory side, if grant: mem_enable=1, read_enable=1, address=if_addr.
- Memory side, ls grant: mem_enable=1, address=ls_addr; ls_we selects write_enable=1 with to_mem_data=ls_wdata, or read_enable=1.
- Response FSM (registered), states IDLE, RESP_IF, RESP_LS:
  - next state = RESP_IF on an if grant, RESP_LS on an ls read grant, IDLE otherwise (including ls writes).
  - if_rvalid = (state==RESP_IF); ls_rvalid = (state==RESP_LS).
- Read latency is exactly 1 cycle from grant edge to rvalid. Back-to-back reads on either port are sustained at 1 per cycle.
- rdata: equals from_mem_data while that port's rvalid=1. Otherwise it holds the last value delivered to that port; per-port hold registers capture on rvalid.
- Read immediately after a write to the same address returns the new data (memory serializes; no forwarding needed).
- Reset (asynchronous): state=IDLE, streak=0, hold registers=0, counters=0. While reset=1, all grants and memory strobes are forced to 0, address/data are 0, and rvalid=0.
- Reset asserted with a read outstanding: the response is dropped, and no rvalid appears after release.

Optional Feature:
MEMARB_PERF_CNT_EN. When defined, perf_if_grants, perf_ls_grants and perf_conflicts increment on each respective event and saturate at all-ones; they are cleared only by reset. When undefined, the counters are not built and the three ports are tied to 0.

Decomposition:
- Shared package mem_arb_pkg: resp_state_t enum (IDLE, RESP_IF, RESP_LS), default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module: mem_arb_perf_cnt, a saturating counter instantiated three times, present only under MEMARB_PERF_CNT_EN.

Test Plan:
1. After reset release, if_req=1, if_addr=0x010 for 4 cycles, memory word 0x010=0xBEEF → if_gnt=1 every cycle, if_rvalid=1 from the cycle after the first grant, if_rdata=0xBEEF; ls ports idle.
2. ls write (ls_addr=0x123, ls_wdata=0xA5A5), then ls read 0x123 → ls_gnt in consecutive cycles, write_enable pulsed once, ls_rvalid one cycle after the read grant with ls_rdata=0xA5A5, ls_rvalid never asserted for the write.
3. if_req and ls_req both held high for 20 cycles, MAX_LS_STREAK=4 → grant pattern of 4 ls then 1 if, repeating. With MEMARB_PERF_CNT_EN: perf_ls_grants=16, perf_if_grants=4, perf_conflicts=20.
4. Alternate if read 0x001 (data 0x1111) and ls read 0x002 (data 0x2222) → each rvalid asserts only on its own port; rdata holds 0x1111/0x2222 between pulses.
5. Assert reset one cycle after an ls read grant → ls_rvalid stays 0, all outputs 0 during reset, no spurious rvalid after release.
6. Build without MEMARB_PERF_CNT_EN, rerun scenario 3 → same grant pattern, perf outputs constant 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_LS = 2'd2
   } resp_state_t;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; slave is the arbiter view.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  ls_req;
   logic                  ls_we;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [DATA_WIDTH-1:0] ls_wdata;
   logic                  ls_gnt;
   logic                  ls_rvalid;
   logic [DATA_WIDTH-1:0] ls_rdata;
   logic                  to_mem_mem_enable;
   logic                  to_mem_read_enable;
   logic                  to_mem_write_enable;
   logic [ADDR_WIDTH-1:0] to_mem_address;
   logic [DATA_WIDTH-1:0] to_mem_data;
   logic [DATA_WIDTH-1:0] from_mem_data;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, from_mem_data,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      output to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable,
      output to_mem_address, to_mem_data
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, from_mem_data,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      input  to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable,
      input  to_mem_address, to_mem_data
   );
endinterface

// File: rtl/mem_port_arbiter_perf_cnt.sv
// Saturating event counter, cleared only by reset.
module mem_arb_perf_cnt #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one synchronous memory port with 1-cycle read routing.
// Optional performance counters are built when MEMARB_PERF_CNT_EN is defined.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int MAX_LS_STREAK = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus,
   output logic [CNT_WIDTH-1:0] perf_if_grants,
   output logic [CNT_WIDTH-1:0] perf_ls_grants,
   output logic [CNT_WIDTH-1:0] perf_conflicts
);
   localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

   logic [STREAK_W-1:0]   streak;
   logic                  ls_win;
   logic                  if_gnt;
   logic                  ls_gnt;
   resp_state_t           state;
   resp_state_t           next_state;
   logic [DATA_WIDTH-1:0] if_hold;
   logic [DATA_WIDTH-1:0] ls_hold;

   // Grants are gated by reset so nothing reaches memory while it is held.
   always_comb begin
      ls_win = bus.ls_req && (!bus.if_req || (streak < STREAK_MAX));
      ls_gnt = !reset && ls_win;
      if_gnt = !reset && bus.if_req && !ls_win;
   end

   always_comb begin
      bus.to_mem_mem_enable   = 1'b0;
      bus.to_mem_read_enable  = 1'b0;
      bus.to_mem_write_enable = 1'b0;
      bus.to_mem_address      = '0;
      bus.to_mem_data         = '0;
      if (if_gnt) begin
         bus.to_mem_mem_enable  = 1'b1;
         bus.to_mem_read_enable = 1'b1;
         bus.to_mem_address     = bus.if_addr;
      end else if (ls_gnt) begin
         bus.to_mem_mem_enable = 1'b1;
         bus.to_mem_address    = bus.ls_addr;
         if (bus.ls_we) begin
            bus.to_mem_write_enable = 1'b1;
            bus.to_mem_data         = bus.ls_wdata;
         end else begin
            bus.to_mem_read_enable = 1'b1;
         end
      end
   end

   // Streak only counts load/store wins while fetch is actually waiting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         streak <= '0;
      end else if (if_gnt || !bus.if_req) begin
         streak <= '0;
      end else if (ls_gnt && (streak != STREAK_MAX)) begin
         streak <= streak + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = IDLE;
      if (if_gnt) begin
         next_state = RESP_IF;
      end else if (ls_gnt && !bus.ls_we) begin
         next_state = RESP_LS;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         if_hold <= '0;
         ls_hold <= '0;
      end else begin
         if (state == RESP_IF) if_hold <= bus.from_mem_data;
         if (state == RESP_LS) ls_hold <= bus.from_mem_data;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.ls_gnt    = ls_gnt;
   assign bus.if_rvalid = (state == RESP_IF);
   assign bus.ls_rvalid = (state == RESP_LS);
   assign bus.if_rdata  = (state == RESP_IF) ? bus.from_mem_data : if_hold;
   assign bus.ls_rdata  = (state == RESP_LS) ? bus.from_mem_data : ls_hold;

`ifdef MEMARB_PERF_CNT_EN
   mem_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_if (
      .clock(clock), .reset(reset), .inc(if_gnt), .count(perf_if_grants)
   );
   mem_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_ls (
      .clock(clock), .reset(reset), .inc(ls_gnt), .count(perf_ls_grants)
   );
   mem_arb_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_conflict (
      .clock(clock), .reset(reset), .inc(bus.if_req && bus.ls_req && !reset),
      .count(perf_conflicts)
   );
`else
   assign perf_if_grants = '0;
   assign perf_ls_grants = '0;
   assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; perf expectations follow MEMARB_PERF_CNT_EN.
module tb_mem_port_arbiter;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] perf_if_grants;
   logic [15:0] perf_ls_grants;
   logic [15:0] perf_conflicts;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] if_q[$];
   logic [15:0] ls_q[$];
   logic [15:0] mexp;

   logic        pre_en   = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [15:0] pre_data = '0;
   logic [15:0] mem [0:4095];

   mem_port_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(12), .DATA_WIDTH(16), .MAX_LS_STREAK(4), .CNT_WIDTH(16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus.slave),
      .perf_if_grants (perf_if_grants),
      .perf_ls_grants (perf_ls_grants),
      .perf_conflicts (perf_conflicts)
   );

   always #5 clock = ~clock;

   // Synchronous memory device with 1-cycle read latency.
   always @(posedge clock) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (bus.to_mem_mem_enable && bus.to_mem_write_enable)
         mem[bus.to_mem_address] <= bus.to_mem_data;
      if (bus.to_mem_mem_enable && bus.to_mem_read_enable)
         bus.from_mem_data <= mem[bus.to_mem_address];
   end

   // Read responses: each queued entry must appear on the very next cycle.
   always @(negedge clock) begin
      n_cmp++;
      if (bus.if_rvalid) begin
         if (if_q.size() == 0) begin
            n_fail++;
            $display("FAIL if_rvalid_spurious: got 1 want 0 at %0t", $time);
         end else begin
            mexp = if_q.pop_front();
            if (bus.if_rdata !== mexp) begin
               n_fail++;
               $display("FAIL if_rdata: got %h want %h at %0t", bus.if_rdata, mexp, $time);
            end
         end
      end else if (if_q.size() != 0) begin
         n_fail++;
         $display("FAIL if_rvalid_missing: got 0 want 1 at %0t", $time);
         void'(if_q.pop_front());
      end
      n_cmp++;
      if (bus.ls_rvalid) begin
         if (ls_q.size() == 0) begin
            n_fail++;
            $display("FAIL ls_rvalid_spurious: got 1 want 0 at %0t", $time);
         end else begin
            mexp = ls_q.pop_front();
            if (bus.ls_rdata !== mexp) begin
               n_fail++;
               $display("FAIL ls_rdata: got %h want %h at %0t", bus.ls_rdata, mexp, $time);
            end
         end
      end else if (ls_q.size() != 0) begin
         n_fail++;
         $display("FAIL ls_rvalid_missing: got 0 want 1 at %0t", $time);
         void'(ls_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = '0;
      bus.ls_wdata = '0;
   endtask

   task automatic preload(input logic [11:0] a, input logic [15:0] d);
      tick();
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      // requests asserted during reset must not leak through
      tick();
      bus.if_req  = 1'b1;
      bus.if_addr = 12'h0AA;
      bus.ls_req  = 1'b1;
      bus.ls_addr = 12'h055;
      @(negedge clock);
      n_cmp++;
      if ({bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable, bus.to_mem_read_enable,
           bus.to_mem_write_enable, bus.to_mem_address, bus.to_mem_data} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got gnt=%b%b en=%b addr=%h want all 0",
                  bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable, bus.to_mem_address);
      end
      n_cmp++;
      if ({bus.if_rdata, bus.ls_rdata, perf_if_grants, perf_ls_grants, perf_conflicts} !== 80'd0) begin
         n_fail++;
         $display("FAIL reset_data: got rdata %h/%h perf %h/%h/%h want 0",
                  bus.if_rdata, bus.ls_rdata, perf_if_grants, perf_ls_grants, perf_conflicts);
      end
      tick();
      idle_inputs();
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got gnt=%b%b en=%b want 000",
                  bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable);
      end
   endtask

   task automatic test_fetch_stream();
      logic pend = 1'b0;
      preload(12'h010, 16'hBEEF);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (pend) if_q.push_back(16'hBEEF);
         bus.if_req  = 1'b1;
         bus.if_addr = 12'h010;
         @(negedge clock);
         n_cmp++;
         if ({bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable, bus.to_mem_read_enable,
              bus.to_mem_write_enable, bus.to_mem_address} !== {5'b10110, 12'h010}) begin
            n_fail++;
            $display("FAIL fetch_grant[%0d]: got gnt=%b%b en/rd/wr=%b%b%b addr=%h want 10 110 010", i,
                     bus.if_gnt, bus.ls_gnt, bus.to_mem_mem_enable, bus.to_mem_read_enable,
                     bus.to_mem_write_enable, bus.to_mem_address);
         end
         pend = 1'b1;
      end
      tick();
      if (pend) if_q.push_back(16'hBEEF);
      idle_inputs();
      tick();
      @(negedge clock);
      n_cmp++;
      if ({bus.if_rvalid, bus.if_rdata} !== {1'b0, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL fetch_hold: got rvalid=%b rdata=%h want 0 beef", bus.if_rvalid, bus.if_rdata);
      end
   endtask

   task automatic test_write_read();
      tick();
      bus.ls_req   = 1'b1;
      bus.ls_we    = 1'b1;
      bus.ls_addr  = 12'h123;
      bus.ls_wdata = 16'hA5A5;
      @(negedge clock);
      n_cmp++;
      if ({bus.ls_gnt, bus.if_gnt, bus.to_mem_write_enable, bus.to_mem_read_enable,
           bus.to_mem_address, bus.to_mem_data} !== {4'b1010, 12'h123, 16'hA5A5}) begin
         n_fail++;
         $display("FAIL ls_write: got gnt=%b wr/rd=%b%b addr=%h data=%h want 1 10 123 a5a5",
                  bus.ls_gnt, bus.to_mem_write_enable, bus.to_mem_read_enable,
                  bus.to_mem_address, bus.to_mem_data);
      end
      tick();
      bus.ls_we    = 1'b0;
      bus.ls_wdata = 16'h0000;
      @(negedge clock);
      n_cmp++;
      if ({bus.ls_gnt, bus.to_mem_write_enable, bus.to_mem_read_enable,
           bus.to_mem_address, bus.to_mem_data} !== {3'b101, 12'h123, 16'h0000}) begin
         n_fail++;
         $display("FAIL ls_read: got gnt=%b wr/rd=%b%b addr=%h data=%h want 1 01 123 0000",
                  bus.ls_gnt, bus.to_mem_write_enable, bus.to_mem_read_enable,
                  bus.to_mem_address, bus.to_mem_data);
      end
      tick();
      ls_q.push_back(16'hA5A5);
      idle_inputs();
      @(negedge clock);
      n_cmp++;
      if (bus.to_mem_write_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL write_pulse: got %b want 0", bus.to_mem_write_enable);
      end
   endtask

   task automatic test_streak();
      logic pend_if = 1'b0;
      logic pend_ls = 1'b0;
      logic exp_ls;
      do_reset();
      preload(12'h020, 16'h1234);
      preload(12'h030, 16'h5678);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pend_if) if_q.push_back(16'h1234);
         if (pend_ls) ls_q.push_back(16'h5678);
         bus.if_req  = 1'b1;
         bus.if_addr = 12'h020;
         bus.ls_req  = 1'b1;
         bus.ls_we   = 1'b0;
         bus.ls_addr = 12'h030;
         exp_ls = ((i % 5) != 4);
         @(negedge clock);
         n_cmp++;
         if ({bus.if_gnt, bus.ls_gnt} !== {!exp_ls, exp_ls}) begin
            n_fail++;
            $display("FAIL streak_pattern[%0d]: got if/ls=%b%b want %b%b", i,
                     bus.if_gnt, bus.ls_gnt, !exp_ls, exp_ls);
         end
         pend_if = !exp_ls;
         pend_ls = exp_ls;
      end
      tick();
      if (pend_if) if_q.push_back(16'h1234);
      if (pend_ls) ls_q.push_back(16'h5678);
      idle_inputs();
      @(negedge clock);
      n_cmp++;
`ifdef MEMARB_PERF_CNT_EN
      if ({perf_ls_grants, perf_if_grants, perf_conflicts} !== {16'd16, 16'd4, 16'd20}) begin
         n_fail++;
         $display("FAIL perf_counts: got ls=%0d if=%0d conf=%0d want 16 4 20",
                  perf_ls_grants, perf_if_grants, perf_conflicts);
      end
`else
      if ({perf_ls_grants, perf_if_grants, perf_conflicts} !== 48'd0) begin
         n_fail++;
         $display("FAIL perf_counts: got ls=%0d if=%0d conf=%0d want 0 0 0",
                  perf_ls_grants, perf_if_grants, perf_conflicts);
      end
`endif
   endtask

   task automatic test_alternate();
      logic pend_if = 1'b0;
      logic pend_ls = 1'b0;
      do_reset();
      preload(12'h001, 16'h1111);
      preload(12'h002, 16'h2222);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pend_if) if_q.push_back(16'h1111);
         if (pend_ls) ls_q.push_back(16'h2222);
         idle_inputs();
         if (i % 2 == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 12'h001;
         end else begin
            bus.ls_req  = 1'b1;
            bus.ls_addr = 12'h002;
         end
         @(negedge clock);
         n_cmp++;
         if ({bus.if_gnt, bus.ls_gnt} !== {(i % 2 == 0), (i % 2 == 1)}) begin
            n_fail++;
            $display("FAIL alt_grant[%0d]: got if/ls=%b%b", i, bus.if_gnt, bus.ls_gnt);
         end
         if (i >= 2) begin
            n_cmp++;
            if ((i % 2 == 0) ? (bus.if_rdata !== 16'h1111) : (bus.ls_rdata !== 16'h2222)) begin
               n_fail++;
               $display("FAIL alt_hold[%0d]: got if=%h ls=%h want 1111/2222", i,
                        bus.if_rdata, bus.ls_rdata);
            end
         end
         pend_if = (i % 2 == 0);
         pend_ls = (i % 2 == 1);
      end
      tick();
      if (pend_if) if_q.push_back(16'h1111);
      if (pend_ls) ls_q.push_back(16'h2222);
      idle_inputs();
      @(negedge clock);
   endtask

   task automatic test_reset_mid_read();
      preload(12'h040, 16'h7777);
      tick();
      bus.ls_req  = 1'b1;
      bus.ls_addr = 12'h040;
      @(negedge clock);
      n_cmp++;
      if (bus.ls_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_read_grant: got %b want 1", bus.ls_gnt);
      end
      tick();
      idle_inputs();
      bus.ls_req  = 1'b1;
      bus.ls_addr = 12'h040;
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({bus.ls_rvalid, bus.ls_gnt, bus.if_gnt, bus.to_mem_mem_enable, bus.to_mem_address,
           bus.ls_rdata, bus.if_rdata} !== 48'd0) begin
         n_fail++;
         $display("FAIL mid_read_reset: got rv=%b gnt=%b en=%b addr=%h rdata=%h want 0",
                  bus.ls_rvalid, bus.ls_gnt, bus.to_mem_mem_enable, bus.to_mem_address, bus.ls_rdata);
      end
      tick();
      idle_inputs();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({bus.ls_rvalid, bus.if_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_rvalid[%0d]: got %b%b want 00", i, bus.ls_rvalid, bus.if_rvalid);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fetch_stream();
      test_write_read();
      test_streak();
      test_alternate();
      test_reset_mid_read();
      tick();
      n_cmp++;
      if ((if_q.size() + ls_q.size()) != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", if_q.size() + ls_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
